// File: rtl/eddsa_block_feeder.sv
// Double-buffered message block assembler for the EdDSA25519 core: packs host
// words MSB-first into 1024-bit blocks and hands them over on block_ready edges.
module eddsa_block_feeder #(
    parameter int WIDTH      = 64,
    parameter int SIZE_BLOCK = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    input  logic                  block_ready,
    output logic [SIZE_BLOCK-1:0] message,
    output logic [1:0]            block_valid,
    output logic                  underrun,
    output logic [WIDTH-1:0]      blocks_sent
);

    localparam int WORDS = SIZE_BLOCK / WIDTH;
    localparam int CNT_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_FILLING,
        SLOT_FULL
    } slot_state_t;

    slot_state_t           slot_state [2];
    logic [SIZE_BLOCK-1:0] slot_data  [2];

    logic             wsel;
    logic             rsel;
    logic [CNT_W-1:0] wcnt;
    logic             pending;
    logic             block_ready_q;

    logic accept;
    logic req;
    logic word_final;
    logic rsel_full;
    logic deliver;

    assign wr_ready   = (slot_state[wsel] != SLOT_FULL);
    assign accept     = wr_valid && wr_ready;
    assign req        = block_ready && !block_ready_q;
    assign word_final = wr_last || (wcnt == CNT_W'(WORDS - 1));
    assign rsel_full  = (slot_state[rsel] == SLOT_FULL);
    // A pending request is served as soon as the read slot is full; a fresh
    // request arriving while one is pending adds nothing.
    assign deliver    = rsel_full && (pending || req);

    // Control state and the registered core-facing outputs
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot_state[0] <= SLOT_EMPTY;
            slot_state[1] <= SLOT_EMPTY;
            wsel          <= 1'b0;
            rsel          <= 1'b0;
            wcnt          <= '0;
            pending       <= 1'b0;
            block_ready_q <= 1'b0;
            message       <= '0;
            block_valid   <= 2'b00;
            underrun      <= 1'b0;
            blocks_sent   <= '0;
        end else begin
            block_ready_q <= block_ready;

            if (accept) begin
                if (word_final) begin
                    slot_state[wsel] <= SLOT_FULL;
                    wcnt             <= '0;
                    wsel             <= ~wsel;
                end else begin
                    slot_state[wsel] <= SLOT_FILLING;
                    wcnt             <= wcnt + CNT_W'(1);
                end
            end

            // accept only touches a non-full slot and deliver only a full one,
            // so the two slot_state updates never collide.
            if (deliver) begin
                message          <= slot_data[rsel];
                slot_state[rsel] <= SLOT_EMPTY;
                rsel             <= ~rsel;
                pending          <= 1'b0;
                blocks_sent      <= blocks_sent + WIDTH'(1);
                block_valid      <= (block_valid == 2'b10) ? 2'b01 : 2'b10;
            end else if (req && !pending) begin
                pending  <= 1'b1;
                underrun <= 1'b1;
            end
        end
    end

    // Slot storage; stale contents are harmless because the slot state gates them
    always_ff @(posedge clk) begin
        if (!rst && !clear && accept) begin
            for (int k = 0; k < WORDS; k++) begin
                if (k == int'(wcnt)) begin
                    slot_data[wsel][SIZE_BLOCK-1-k*WIDTH -: WIDTH] <= wr_data;
                end else if (wr_last && (k > int'(wcnt))) begin
                    slot_data[wsel][SIZE_BLOCK-1-k*WIDTH -: WIDTH] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eddsa_block_feeder.sv
// Bench for eddsa_block_feeder: table of block transactions, hand-built corner
// sequences, and a randomized run checked cycle by cycle against a queue model.
module tb_eddsa_block_feeder;

    localparam int WIDTH      = 64;
    localparam int SIZE_BLOCK = 1024;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic [WIDTH-1:0]      wr_data;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  block_ready;
    logic [SIZE_BLOCK-1:0] message;
    logic [1:0]            block_valid;
    logic                  underrun;
    logic [WIDTH-1:0]      blocks_sent;

    eddsa_block_feeder #(.WIDTH(WIDTH), .SIZE_BLOCK(SIZE_BLOCK)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .block_ready (block_ready),
        .message     (message),
        .block_valid (block_valid),
        .underrun    (underrun),
        .blocks_sent (blocks_sent)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: completed blocks wait in a FIFO of at most two entries
    logic [SIZE_BLOCK-1:0] m_q [$];
    logic [SIZE_BLOCK-1:0] m_part;
    int                    m_pcnt;
    bit                    m_pend;
    bit                    m_brq;
    logic [SIZE_BLOCK-1:0] m_msg;
    logic [1:0]            m_bv;
    bit                    m_und;
    logic [WIDTH-1:0]      m_sent;

    task automatic model_reset();
        m_q.delete();
        m_part = '0;
        m_pcnt = 0;
        m_pend = 0;
        m_brq  = 0;
        m_msg  = '0;
        m_bv   = 2'b00;
        m_und  = 0;
        m_sent = '0;
    endtask

    task automatic model_edge();
        bit req, acc, dlv;
        if (rst || clear) begin
            model_reset();
            return;
        end
        req = block_ready && !m_brq;
        acc = wr_valid && (m_q.size() < 2);
        dlv = 0;
        if (m_pend) begin
            if (m_q.size() > 0) dlv = 1;
        end else if (req) begin
            if (m_q.size() > 0) dlv = 1;
            else begin
                m_pend = 1;
                m_und  = 1;
            end
        end
        if (dlv) begin
            m_msg  = m_q.pop_front();
            m_pend = 0;
            m_sent = m_sent + 1;
            m_bv   = (m_bv == 2'b10) ? 2'b01 : 2'b10;
        end
        if (acc) begin
            if (m_pcnt == 0) m_part = '0;
            m_part[SIZE_BLOCK-1-m_pcnt*WIDTH -: WIDTH] = wr_data;
            m_pcnt++;
            if (wr_last || m_pcnt == SIZE_BLOCK / WIDTH) begin
                m_q.push_back(m_part);
                m_pcnt = 0;
            end
        end
        m_brq = block_ready;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [SIZE_BLOCK-1:0] m, input int k);
        return m[SIZE_BLOCK-1-k*WIDTH -: WIDTH];
    endfunction

    task automatic check_model();
        n_total++;
        if (message !== m_msg) begin
            n_bad++;
            $display("FAIL model_message t=%0t act_hi=%h act_lo=%h exp_hi=%h exp_lo=%h", $time,
                     word_of(message, 0), word_of(message, 15), word_of(m_msg, 0), word_of(m_msg, 15));
        end
        chk("model_block_valid", 64'(block_valid), 64'(m_bv));
        chk("model_underrun", 64'(underrun), 64'(m_und));
        chk("model_blocks_sent", blocks_sent, m_sent);
        chk("model_wr_ready", 64'(wr_ready), 64'(m_q.size() < 2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic write_word(input logic [63:0] d, input bit last);
        wr_data  = d;
        wr_valid = 1'b1;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic write_block(input logic [63:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++) write_word(base + 64'(i), last && (i == n - 1));
    endtask

    task automatic request();
        block_ready = 1'b0;
        tick();
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
    endtask

    typedef struct {
        int          nwords;
        bit          last;
        logic [63:0] base;
        logic [63:0] exp_w0;
        logic [63:0] exp_w15;
        logic [1:0]  exp_bv;
        logic [63:0] exp_sent;
    } vec_t;

    vec_t tv [4];

    initial begin
        tv[0] = '{16, 1'b0, 64'h1, 64'h1, 64'h10, 2'b10, 64'd1};
        tv[1] = '{1, 1'b1, 64'h89010d8559720000, 64'h89010d8559720000, 64'h0, 2'b01, 64'd2};
        tv[2] = '{5, 1'b1, 64'hA000, 64'hA000, 64'h0, 2'b10, 64'd3};
        tv[3] = '{16, 1'b0, 64'hFFFFFFFFFFFFFFF0, 64'hFFFFFFFFFFFFFFF0, 64'hFFFFFFFFFFFFFFFF, 2'b01, 64'd4};

        rst = 1'b1; clear = 1'b0; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0; block_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_message_hi", word_of(message, 0), 64'h0);
        chk("rst_block_valid", 64'(block_valid), 64'h0);
        chk("rst_underrun", 64'(underrun), 64'h0);
        chk("rst_blocks_sent", blocks_sent, 64'h0);
        chk("rst_wr_ready", 64'(wr_ready), 64'h1);

        for (int i = 0; i < 4; i++) begin
            write_block(tv[i].base, tv[i].nwords, tv[i].last);
            request();
            chk($sformatf("tv%0d_w0", i), word_of(message, 0), tv[i].exp_w0);
            chk($sformatf("tv%0d_w15", i), word_of(message, 15), tv[i].exp_w15);
            chk($sformatf("tv%0d_bv", i), 64'(block_valid), 64'(tv[i].exp_bv));
            chk($sformatf("tv%0d_sent", i), blocks_sent, tv[i].exp_sent);
        end
        chk("short_msg_tail", 64'(message === {64'h89010d8559720000, 960'h0}), 64'h0);

        // Double buffering: two blocks queued, third written after second delivery
        write_block(64'h200, 16, 1'b0);
        chk("db_ready_after_first", 64'(wr_ready), 64'h1);
        write_block(64'h300, 16, 1'b0);
        chk("db_ready_both_full", 64'(wr_ready), 64'h0);
        request();
        chk("db1_bv", 64'(block_valid), 64'h2);
        chk("db1_w0", word_of(message, 0), 64'h200);
        chk("db1_ready_back", 64'(wr_ready), 64'h1);
        request();
        chk("db2_bv", 64'(block_valid), 64'h1);
        chk("db2_w0", word_of(message, 0), 64'h300);
        write_block(64'h400, 16, 1'b0);
        request();
        chk("db3_bv", 64'(block_valid), 64'h2);
        chk("db3_sent", blocks_sent, 64'd7);
        chk("db_no_underrun", 64'(underrun), 64'h0);

        // Underrun: request with both slots empty, delivered once a block completes
        request();
        chk("ur_flag", 64'(underrun), 64'h1);
        chk("ur_bv_hold", 64'(block_valid), 64'h2);
        write_block(64'h500, 16, 1'b0);
        chk("ur_bv_at_full", 64'(block_valid), 64'h2);
        tick();
        chk("ur_bv_delivered", 64'(block_valid), 64'h1);
        chk("ur_w0", word_of(message, 0), 64'h500);
        chk("ur_sent", blocks_sent, 64'd8);

        // Request in the same cycle as the final word
        rst = 1'b1;
        tick();
        rst = 1'b0;
        write_block(64'h600, 15, 1'b0);
        wr_data = 64'h60F; wr_valid = 1'b1; block_ready = 1'b1;
        tick();
        wr_valid = 1'b0; block_ready = 1'b0;
        chk("sim_bv_c1", 64'(block_valid), 64'h0);
        chk("sim_underrun", 64'(underrun), 64'h1);
        tick();
        chk("sim_bv_c2", 64'(block_valid), 64'h2);
        chk("sim_sent", blocks_sent, 64'd1);
        chk("sim_w15", word_of(message, 15), 64'h60F);

        // Clear after 7 words, then a clean block
        write_block(64'hDEAD0000, 7, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_bv", 64'(block_valid), 64'h0);
        chk("clr_wr_ready", 64'(wr_ready), 64'h1);
        chk("clr_sent", blocks_sent, 64'h0);
        chk("clr_underrun", 64'(underrun), 64'h0);
        write_block(64'h700, 16, 1'b0);
        request();
        chk("clr_w0", word_of(message, 0), 64'h700);
        chk("clr_w6", word_of(message, 6), 64'h706);
        chk("clr_bv_after", 64'(block_valid), 64'h2);

        // Randomized traffic, checked every cycle against the model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            wr_valid    = ($urandom_range(0, 3) != 0);
            wr_last     = ($urandom_range(0, 9) == 0);
            wr_data     = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) block_ready = ~block_ready;
            clear       = ($urandom_range(0, 299) == 0);
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0; clear = 1'b0; block_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/eddsa_block_feeder.md
Name: eddsa_block_feeder

Overview:
- Upstream stage of the EdDSA25519 cryptocore. Assembles 64-bit host words into 1024-bit message blocks and hands them to the core over its block_ready/block_valid handshake.
- Double-buffered: the host fills one block slot while the core consumes the other.
- Sits between the PYNQ-Z2 AXI register interface and the core's message, block_valid and block_ready ports.

Parameters:
- WIDTH, 64, host word width in bits.
- SIZE_BLOCK, 1024, message block width in bits. WORDS = SIZE_BLOCK/WIDTH = 16, derived internally and not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clear  in  1  synchronous abort: empties both slots and sets block_valid to 2'b00; the word counter is cleared
- wr_data  in  WIDTH  host word, MSB-first within the block
- wr_valid  in  1  wr_data is valid this cycle
- wr_last  in  1  with wr_valid: final word of the message; the rest of the block is zero-padded
- wr_ready  out  1  the current fill slot can accept a word
- block_ready  in  1  core requests the next block; level signal, acted on at its rising edge
- message  out  SIZE_BLOCK  block presented to the core
- block_valid  out  2  block-available code for the core
- underrun  out  1  sticky: core requested while no block was FULL
- blocks_sent  out  WIDTH  count of blocks delivered since rst/clear

Behaviour:
- Reset and clear (clear has identical effect):
  - Outputs: message=0, block_valid=2'b00, underrun=0, blocks_sent=0, wr_ready=1.
  - Internal: both slots EMPTY, wsel=rsel=0, word count=0, pending=0, block_ready history register=0.
  - rst has priority over clear; clear has priority over all other activity that cycle.
  - Reset or clear mid-block discards any partial data.
- Slot state machine (per slot): EMPTY -> FILLING on the first accepted word; FILLING -> FULL on the 16th word or on a word with wr_last; FULL -> EMPTY when the slot is delivered.
- Write path:
  - A word is accepted when wr_valid && wr_ready.
  - Word k (0..15) is stored at bits [SIZE_BLOCK-1-k*WIDTH -: WIDTH].
  - On wr_last, words k+1..15 are forced to 0.
  - When the slot goes FULL, the word count resets to 0 and wsel toggles.
  - wr_ready = (slot[wsel] != FULL).
  - A write while wr_ready=0 is ignored and leaves no state change.
- Request detection:
  - Request = block_ready && !block_ready_q, where block_ready_q is block_ready registered.
  - On a request: if slot[rsel] is FULL, deliver at the next edge. Otherwise set pending=1 and underrun=1.
- Delivery (one cycle after the request, or one cycle after slot[rsel] becomes FULL while pending):
  - message <= slot[rsel]; slot[rsel] -> EMPTY; rsel toggles; pending <= 0; blocks_sent += 1.
  - block_valid sequence: 00 -> 10; 10 -> 01; 01 -> 10. Each new block therefore changes the code.
- Simultaneous events:
  - Request in the same cycle that slot[rsel] receives its final word: the FULL state is visible next cycle, so the request is treated as pending and delivered 2 cycles after the request. underrun is still set.
  - Host writing slot[wsel] while slot[rsel] is delivered: both proceed; the slots are independent.
  - A second request while pending=1 is ignored; at most one request is outstanding.
- message and block_valid hold their values between deliveries. blocks_sent wraps modulo 2^WIDTH.
- The block does not interpret message length. len_message remains the host's responsibility.

Test Plan:
- Basic delivery: rst, write 16 words 0x0000000000000001..0x0000000000000010, then pulse block_ready -> one cycle after the edge, message[1023:960]=0x1 and message[63:0]=0x10; block_valid=2'b10; blocks_sent=1.
- Short message: write 0x89010d8559720000 with wr_last, then request -> message = {64'h89010d8559720000, 960'h0}; block_valid=2'b10.
- Double buffering and toggle: fill 2 blocks (wr_ready drops after the 2nd), then issue 3 requests with 1 more block written after the 2nd -> block_valid sequence 10, 01, 10; wr_ready reasserts one cycle after the first delivery; no underrun.
- Underrun: request with both slots EMPTY -> underrun=1, block_valid unchanged. After 16 words are written, delivery occurs on the cycle following FULL.
- Simultaneous: request in the same cycle as the 16th word -> delivery 2 cycles after the request; underrun=1.
- clear mid-fill after 7 words -> block_valid=2'b00 and wr_ready=1. A subsequent full block is delivered with no residue from the 7 discarded words.
